// File: rtl/store_buffer_pkg.sv
// Shared types and sizes for the in-order store buffer: entry layout,
// wrap-bit pointer type and pointer helpers.
package store_buffer_pkg;

  localparam int STORE_BUFFER_LENGTH = 8;
  localparam int SB_LEN              = STORE_BUFFER_LENGTH;
  localparam int SB_PW               = $clog2(SB_LEN);
  localparam int ROB_AW              = 5;
  localparam int AW                  = 16;
  localparam int DW                  = 16;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [SB_PW:0]   sb_ptr_t;
  typedef logic [SB_PW-1:0] sb_idx_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_AW-1:0] rob_addr;
    logic              addr_ready;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              committed;
  } sb_entry_t;

  function automatic sb_idx_t ptr_idx(input sb_ptr_t p);
    return p[SB_PW-1:0];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of every store-buffer port except clock and reset; the slave
// modport is the store buffer itself, master is the core / memory side.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              alloc_valid;
  logic [ROB_AW-1:0] alloc_rob_addr;
  logic              alloc_ready;
  sb_ptr_t           sb_tail;

  logic              exec_valid;
  logic [ROB_AW-1:0] exec_rob_addr;
  logic [AW-1:0]     exec_addr;
  logic [DW-1:0]     exec_data;

  logic              commit_valid;
  logic [ROB_AW-1:0] commit_rob_addr;
  logic              commit_err;
  logic              flush;

  // Drain channel: mem_req_valid/addr/data hold steady while
  // mem_req_valid=1 and mem_req_ready=0; a transfer happens on any rising
  // clk edge where both mem_req_valid and mem_req_ready are 1.
  logic              mem_req_valid;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic              mem_req_ready;

  logic              ld_valid;
  logic [AW-1:0]     ld_addr;
  sb_ptr_t           ld_sb_tail;
  logic              ld_fwd_hit;
  logic [DW-1:0]     ld_fwd_data;
  logic              ld_fwd_stall;

  logic              empty;
  logic              full;
  sb_ptr_t           dbg_head;
  sb_ptr_t           dbg_cmt;

  modport slave (
    input  alloc_valid, alloc_rob_addr,
    output alloc_ready, sb_tail,
    input  exec_valid, exec_rob_addr, exec_addr, exec_data,
    input  commit_valid, commit_rob_addr,
    output commit_err,
    input  flush,
    output mem_req_valid, mem_req_addr, mem_req_data,
    input  mem_req_ready,
    input  ld_valid, ld_addr, ld_sb_tail,
    output ld_fwd_hit, ld_fwd_data, ld_fwd_stall,
    output empty, full, dbg_head, dbg_cmt
  );

  modport master (
    output alloc_valid, alloc_rob_addr,
    input  alloc_ready, sb_tail,
    output exec_valid, exec_rob_addr, exec_addr, exec_data,
    output commit_valid, commit_rob_addr,
    input  commit_err,
    output flush,
    input  mem_req_valid, mem_req_addr, mem_req_data,
    output mem_req_ready,
    output ld_valid, ld_addr, ld_sb_tail,
    input  ld_fwd_hit, ld_fwd_data, ld_fwd_stall,
    input  empty, full, dbg_head, dbg_cmt
  );

endinterface

// File: rtl/store_buffer_fwd_lookup.sv
// Store-to-load forwarding: among entries older than the load's tail
// snapshot, stall on any unresolved address, else pick the youngest match.
module store_buffer_fwd_lookup
  import store_buffer_pkg::*;
(
  input  logic [SB_LEN-1:0]         ent_valid,
  input  logic [SB_LEN-1:0]         ent_ready,
  input  logic [SB_LEN-1:0][AW-1:0] ent_addr,
  input  logic [SB_LEN-1:0][DW-1:0] ent_data,
  input  sb_ptr_t                   head,
  input  logic                      ld_valid,
  input  logic [AW-1:0]             ld_addr,
  input  sb_ptr_t                   ld_sb_tail,
  output logic                      fwd_hit,
  output logic [DW-1:0]             fwd_data,
  output logic                      fwd_stall
);

  sb_ptr_t       span;
  logic          span_ok;
  sb_idx_t       age;
  sb_idx_t       best_age;
  logic          in_range;
  logic          found;
  logic          stall;
  logic [DW-1:0] best_data;

  // A snapshot older than head (its stores already drained) wraps to a span
  // above LEN and must select nothing.
  assign span    = ld_sb_tail - head;
  assign span_ok = (span <= sb_ptr_t'(SB_LEN));

  always_comb begin
    age       = '0;
    in_range  = 1'b0;
    found     = 1'b0;
    stall     = 1'b0;
    best_age  = '0;
    best_data = '0;
    for (int i = 0; i < SB_LEN; i++) begin
      age      = sb_idx_t'(i) - ptr_idx(head);
      in_range = span_ok && ({1'b0, age} < span) && ent_valid[i];
      if (in_range && !ent_ready[i]) begin
        stall = 1'b1;
      end
      if (in_range && ent_ready[i] && (ent_addr[i] == ld_addr) &&
          (!found || (age > best_age))) begin
        found     = 1'b1;
        best_age  = age;
        best_data = ent_data[i];
      end
    end
  end

  assign fwd_stall = ld_valid & stall;
  assign fwd_hit   = ld_valid & ~stall & found;
  assign fwd_data  = fwd_hit ? best_data : '0;

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: allocate at dispatch, resolve at execute, commit at
// ROB retire, drain committed stores to D-mem in program order.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);

  sb_entry_t [SB_LEN-1:0] entries;
  sb_ptr_t                head;
  sb_ptr_t                cmt;
  sb_ptr_t                tail;
  sb_ptr_t                occupancy;
  logic                   full;
  logic                   empty;
  logic                   alloc_fire;
  logic                   commit_ok;
  logic                   mem_valid;
  logic                   drain_fire;
  logic                   commit_err_q;
  logic [SB_LEN-1:0]      exec_hit;

  logic [SB_LEN-1:0]         ent_valid;
  logic [SB_LEN-1:0]         ent_ready;
  logic [SB_LEN-1:0][AW-1:0] ent_addr;
  logic [SB_LEN-1:0][DW-1:0] ent_data;

  // Flags come from start-of-cycle pointers, so a full buffer refuses alloc
  // even in a cycle where it is also draining.
  assign occupancy  = tail - head;
  assign full       = (occupancy == sb_ptr_t'(SB_LEN));
  assign empty      = (tail == head);
  assign alloc_fire = sb.alloc_valid & ~full & ~sb.flush;

  assign commit_ok = sb.commit_valid & (cmt != tail) &
                     entries[ptr_idx(cmt)].valid &
                     entries[ptr_idx(cmt)].addr_ready &
                     ~entries[ptr_idx(cmt)].committed &
                     (entries[ptr_idx(cmt)].rob_addr == sb.commit_rob_addr);

  assign mem_valid  = entries[ptr_idx(head)].valid & entries[ptr_idx(head)].committed;
  assign drain_fire = mem_valid & sb.mem_req_ready;

  always_comb begin
    exec_hit = '0;
    for (int i = 0; i < SB_LEN; i++) begin
      exec_hit[i] = sb.exec_valid & ~sb.flush & entries[i].valid &
                    ~entries[i].committed &
                    (entries[i].rob_addr == sb.exec_rob_addr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      cmt          <= '0;
      tail         <= '0;
      commit_err_q <= 1'b0;
    end else begin
      if (drain_fire) head <= head + sb_ptr_t'(1);
      if (commit_ok)  cmt  <= cmt + sb_ptr_t'(1);
      // The commit in a flush cycle still lands; tail follows the new cmt.
      if (sb.flush) begin
        tail <= commit_ok ? (cmt + sb_ptr_t'(1)) : cmt;
      end else if (alloc_fire) begin
        tail <= tail + sb_ptr_t'(1);
      end
      commit_err_q <= sb.commit_valid & ~commit_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else begin
      for (int i = 0; i < SB_LEN; i++) begin
        if (drain_fire && (sb_idx_t'(i) == ptr_idx(head))) begin
          entries[i] <= '0;
        end else begin
          if (commit_ok && (sb_idx_t'(i) == ptr_idx(cmt))) begin
            entries[i].committed <= 1'b1;
          end
          if (sb.flush) begin
            if (entries[i].valid && !entries[i].committed &&
                !(commit_ok && (sb_idx_t'(i) == ptr_idx(cmt)))) begin
              entries[i] <= '0;
            end
          end else if (alloc_fire && (sb_idx_t'(i) == ptr_idx(tail))) begin
            entries[i].valid      <= 1'b1;
            entries[i].rob_addr   <= sb.alloc_rob_addr;
            entries[i].addr_ready <= 1'b0;
            entries[i].addr       <= '0;
            entries[i].data       <= '0;
            entries[i].committed  <= 1'b0;
          end else if (exec_hit[i]) begin
            entries[i].addr_ready <= 1'b1;
            entries[i].addr       <= sb.exec_addr;
            entries[i].data       <= sb.exec_data;
          end
        end
      end
    end
  end

  always_comb begin
    ent_valid = '0;
    ent_ready = '0;
    ent_addr  = '0;
    ent_data  = '0;
    for (int i = 0; i < SB_LEN; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_ready[i] = entries[i].addr_ready;
      ent_addr[i]  = entries[i].addr;
      ent_data[i]  = entries[i].data;
    end
  end

  store_buffer_fwd_lookup u_fwd (
    .ent_valid  (ent_valid),
    .ent_ready  (ent_ready),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data),
    .head       (head),
    .ld_valid   (sb.ld_valid),
    .ld_addr    (sb.ld_addr),
    .ld_sb_tail (sb.ld_sb_tail),
    .fwd_hit    (sb.ld_fwd_hit),
    .fwd_data   (sb.ld_fwd_data),
    .fwd_stall  (sb.ld_fwd_stall)
  );

  assign sb.alloc_ready   = ~full;
  assign sb.sb_tail       = tail;
  assign sb.commit_err    = commit_err_q;
  assign sb.mem_req_valid = mem_valid;
  assign sb.mem_req_addr  = entries[ptr_idx(head)].addr;
  assign sb.mem_req_data  = entries[ptr_idx(head)].data;
  assign sb.empty         = empty;
  assign sb.full          = full;
  assign sb.dbg_head      = head;
  assign sb.dbg_cmt       = cmt;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain traffic goes through an expected
// queue checked by an independent monitor; flags and forwarding checked inline.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   tail_model;
  logic [31:0] exp_q[$];

  store_buffer_if sb ();

  store_buffer dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [ROB_AW-1:0] rob);
    sb.alloc_valid    = 1'b1;
    sb.alloc_rob_addr = rob;
    tick();
    sb.alloc_valid    = 1'b0;
  endtask

  task automatic do_exec(input logic [ROB_AW-1:0] rob, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.exec_valid    = 1'b1;
    sb.exec_rob_addr = rob;
    sb.exec_addr     = a;
    sb.exec_data     = d;
    tick();
    sb.exec_valid    = 1'b0;
  endtask

  task automatic do_commit(input logic [ROB_AW-1:0] rob);
    sb.commit_valid    = 1'b1;
    sb.commit_rob_addr = rob;
    tick();
    sb.commit_valid    = 1'b0;
  endtask

  task automatic ld_query(input logic [AW-1:0] a, input int snap);
    sb.ld_valid   = 1'b1;
    sb.ld_addr    = a;
    sb.ld_sb_tail = sb_ptr_t'(snap);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && sb.mem_req_valid && sb.mem_req_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain_unexpected: got 0x%0h/0x%0h expected no request",
                 sb.mem_req_addr, sb.mem_req_data);
      end else begin
        check("drain", {sb.mem_req_addr, sb.mem_req_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    tail_model = 0;
    rst = 1'b1;
    sb.alloc_valid = 1'b0;  sb.alloc_rob_addr = '0;
    sb.exec_valid = 1'b0;   sb.exec_rob_addr = '0; sb.exec_addr = '0; sb.exec_data = '0;
    sb.commit_valid = 1'b0; sb.commit_rob_addr = '0;
    sb.flush = 1'b0;        sb.mem_req_ready = 1'b0;
    sb.ld_valid = 1'b0;     sb.ld_addr = '0; sb.ld_sb_tail = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    check("rst_empty", 32'(sb.empty), 32'd1);
    check("rst_full", 32'(sb.full), 32'd0);
    check("rst_alloc_ready", 32'(sb.alloc_ready), 32'd1);
    check("rst_mem_valid", 32'(sb.mem_req_valid), 32'd0);
    check("rst_tail", 32'(sb.sb_tail), 32'd0);
    check("rst_commit_err", 32'(sb.commit_err), 32'd0);

    // Single store, drain held off for 5 cycles.
    do_alloc(5'd3); tail_model++;
    do_exec(5'd3, 16'h0040, 16'hBEEF);
    do_commit(5'd3);
    exp_q.push_back({16'h0040, 16'hBEEF});
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(sb.mem_req_valid), 32'd1);
      check("hold_data", {sb.mem_req_addr, sb.mem_req_data}, {16'h0040, 16'hBEEF});
      tick();
    end
    sb.mem_req_ready = 1'b1;
    tick();
    sb.mem_req_ready = 1'b0;
    check("single_empty", 32'(sb.empty), 32'd1);

    // Fill to full; ninth alloc refused.
    for (int i = 0; i < 8; i++) begin
      do_alloc(ROB_AW'(i)); tail_model++;
    end
    check("fill_full", 32'(sb.full), 32'd1);
    check("fill_alloc_ready", 32'(sb.alloc_ready), 32'd0);
    check("fill_tail", 32'(sb.sb_tail), 32'd9);
    do_alloc(5'd8);
    check("ninth_ignored_tail", 32'(sb.sb_tail), 32'd9);
    check("ninth_still_full", 32'(sb.full), 32'd1);
    for (int i = 0; i < 8; i++) do_exec(ROB_AW'(i), AW'(16'h0100 + i), DW'(16'hA000 + i));
    for (int i = 0; i < 8; i++) begin
      do_commit(ROB_AW'(i));
      exp_q.push_back({16'(16'h0100 + i), 16'(16'hA000 + i)});
    end
    sb.mem_req_ready = 1'b1;
    repeat (10) tick();
    check("fill_drained_empty", 32'(sb.empty), 32'd1);

    // Pipelined alloc/exec/commit/drain, wrapping the pointers several times.
    for (int k = 0; k < 22; k++) begin
      sb.alloc_valid     = (k < 20);
      sb.alloc_rob_addr  = ROB_AW'(k + 10);
      sb.exec_valid      = (k >= 1) && (k <= 20);
      sb.exec_rob_addr   = ROB_AW'(k + 9);
      sb.exec_addr       = AW'(16'h0200 + k - 1);
      sb.exec_data       = DW'(16'hC000 + k - 1);
      sb.commit_valid    = (k >= 2);
      sb.commit_rob_addr = ROB_AW'(k + 8);
      if (k >= 2) exp_q.push_back({16'(16'h0200 + k - 2), 16'(16'hC000 + k - 2)});
      if (k < 20) tail_model++;
      tick();
      if (k >= 2) check("pipe_commit_err", 32'(sb.commit_err), 32'd0);
    end
    sb.alloc_valid = 1'b0; sb.exec_valid = 1'b0; sb.commit_valid = 1'b0;
    repeat (3) tick();
    sb.mem_req_ready = 1'b0;
    check("pipe_empty", 32'(sb.empty), 32'd1);
    check("pipe_tail_wrap", 32'(sb.sb_tail), 32'(tail_model % 16));

    // Forwarding: A@0x10=1 then B@0x10=2.
    do_alloc(5'd1); tail_model++;
    do_alloc(5'd2); tail_model++;
    do_exec(5'd2, 16'h0010, 16'h0002);
    ld_query(16'h0010, tail_model);
    check("fwd_a_unresolved_stall", 32'(sb.ld_fwd_stall), 32'd1);
    check("fwd_a_unresolved_hit", 32'(sb.ld_fwd_hit), 32'd0);
    sb.ld_valid = 1'b0;
    do_exec(5'd1, 16'h0010, 16'h0001);
    ld_query(16'h0010, tail_model);
    check("fwd_after_b_hit", 32'(sb.ld_fwd_hit), 32'd1);
    check("fwd_after_b_data", 32'(sb.ld_fwd_data), 32'd2);
    check("fwd_after_b_stall", 32'(sb.ld_fwd_stall), 32'd0);
    ld_query(16'h0010, tail_model - 1);
    check("fwd_between_hit", 32'(sb.ld_fwd_hit), 32'd1);
    check("fwd_between_data", 32'(sb.ld_fwd_data), 32'd1);
    ld_query(16'h0010, tail_model - 2);
    check("fwd_before_a_hit", 32'(sb.ld_fwd_hit), 32'd0);
    ld_query(16'h0020, tail_model);
    check("fwd_other_addr_hit", 32'(sb.ld_fwd_hit), 32'd0);
    sb.ld_valid = 1'b0;
    #1;
    check("fwd_idle_hit", 32'(sb.ld_fwd_hit), 32'd0);
    check("fwd_idle_data", 32'(sb.ld_fwd_data), 32'd0);

    // Flush with 2 committed + 3 uncommitted.
    do_commit(5'd1);
    exp_q.push_back({16'h0010, 16'h0001});
    do_commit(5'd2);
    exp_q.push_back({16'h0010, 16'h0002});
    for (int i = 20; i < 23; i++) do_alloc(ROB_AW'(i));
    do_exec(5'd20, 16'h0099, 16'h9999);
    sb.flush = 1'b1;
    tick();
    sb.flush = 1'b0;
    check("flush_tail_eq_cmt", 32'(sb.sb_tail), 32'(tail_model % 16));
    check("flush_cmt", 32'(sb.dbg_cmt), 32'(tail_model % 16));
    do_exec(5'd21, 16'h0077, 16'h7777);
    sb.mem_req_ready = 1'b1;
    repeat (4) tick();
    sb.mem_req_ready = 1'b0;
    check("flush_drained_empty", 32'(sb.empty), 32'd1);
    check("flush_head", 32'(sb.dbg_head), 32'(tail_model % 16));
    do_alloc(5'd23); tail_model++;
    check("flush_next_alloc_tail", 32'(sb.sb_tail), 32'(tail_model % 16));

    // Commit errors.
    do_commit(5'd23);
    check("err_before_exec", 32'(sb.commit_err), 32'd1);
    check("err_before_exec_cmt", 32'(sb.dbg_cmt), 32'((tail_model - 1) % 16));
    tick();
    check("err_pulse_clears", 32'(sb.commit_err), 32'd0);
    do_exec(5'd23, 16'h0030, 16'h5555);
    do_commit(5'd24);
    check("err_wrong_tag", 32'(sb.commit_err), 32'd1);
    check("err_wrong_tag_cmt", 32'(sb.dbg_cmt), 32'((tail_model - 1) % 16));
    do_commit(5'd23);
    exp_q.push_back({16'h0030, 16'h5555});
    check("good_commit_no_err", 32'(sb.commit_err), 32'd0);
    check("good_commit_cmt", 32'(sb.dbg_cmt), 32'(tail_model % 16));
    do_commit(5'd25);
    check("err_nothing", 32'(sb.commit_err), 32'd1);
    sb.mem_req_ready = 1'b1;
    repeat (3) tick();
    sb.mem_req_ready = 1'b0;
    check("err_phase_empty", 32'(sb.empty), 32'd1);

    // Asynchronous reset in the middle of a pending drain.
    do_alloc(5'd5);
    do_exec(5'd5, 16'h0044, 16'h1234);
    do_commit(5'd5);
    check("pre_rst_valid", 32'(sb.mem_req_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(sb.mem_req_valid), 32'd0);
    check("async_rst_empty", 32'(sb.empty), 32'd1);
    check("async_rst_tail", 32'(sb.sb_tail), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_alloc_ready", 32'(sb.alloc_ready), 32'd1);

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
